// File: rtl/brightness_engine.sv
// brightness_engine: streams a frame from memory, adding a saturating offset per lane.
// Define BRIGHT_FRAME_CNT_EN to build the completed-frame counter on frame_cnt.
module brightness_engine #(
    parameter int PW    = 8,
    parameter int LANES = 4,
    parameter int AW    = 6,
    parameter int DEPTH = 64,
    parameter int STEP  = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cfg_load,
    input  logic [PW:0]         cfg_value,
    input  logic                up,
    input  logic                down,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                mem_rd_en,
    output logic [AW-1:0]       mem_addr,
    input  logic [LANES*PW-1:0] mem_rdata,
    output logic                out_wr_en,
    output logic [AW-1:0]       out_addr,
    output logic [LANES*PW-1:0] out_wdata,
    output logic [PW:0]         offset,
    output logic [15:0]         frame_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int MAXV = (1 << PW) - 1;
    localparam logic signed [PW+1:0] OMAX  = (PW+2)'(MAXV);
    localparam logic signed [PW+1:0] OMIN  = -OMAX;
    localparam logic signed [PW+1:0] STEPV = (PW+2)'(STEP);
    localparam logic [AW-1:0]        LAST  = AW'(DEPTH - 1);

    state_t                 state;
    logic                   drain_cnt;
    logic signed [PW:0]     off_r;
    logic signed [PW:0]     frame_off;
    logic                   up_q;
    logic                   down_q;
    logic                   up_e;
    logic                   down_e;
    logic                   rd_q;
    logic [AW-1:0]          addr_q;
    logic [LANES*PW-1:0]    lane_res;
    logic signed [PW+1:0]   off_ext;
    logic signed [PW+1:0]   cfg_ext;
    logic signed [PW+1:0]   fo_ext;

    function automatic logic signed [PW:0] clamp_off(input logic signed [PW+1:0] v);
        if (v > OMAX)
            return OMAX[PW:0];
        else if (v < OMIN)
            return OMIN[PW:0];
        else
            return v[PW:0];
    endfunction

    assign up_e    = up & ~up_q;
    assign down_e  = down & ~down_q;
    assign off_ext = {off_r[PW], off_r};
    assign cfg_ext = {cfg_value[PW], cfg_value};
    assign fo_ext  = {frame_off[PW], frame_off};
    assign offset  = off_r;

    // Offset register: a load wins over button edges; opposing edges cancel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            off_r  <= '0;
            up_q   <= 1'b0;
            down_q <= 1'b0;
        end else begin
            up_q   <= up;
            down_q <= down;
            if (cfg_load)
                off_r <= clamp_off(cfg_ext);
            else if (up_e && !down_e)
                off_r <= clamp_off(off_ext + STEPV);
            else if (down_e && !up_e)
                off_r <= clamp_off(off_ext - STEPV);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [PW+1:0] s;
        assign s = $signed({2'b00, mem_rdata[i*PW +: PW]}) + fo_ext;
        assign lane_res[i*PW +: PW] = s[PW+1] ? '0 :
                                      (s > OMAX) ? {PW{1'b1}} : s[PW-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            drain_cnt <= 1'b0;
            frame_off <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            out_wr_en <= 1'b0;
            out_addr  <= '0;
            out_wdata <= '0;
        end else begin
            rd_q      <= mem_rd_en;
            addr_q    <= mem_addr;
            out_wr_en <= rd_q;
            if (rd_q) begin
                out_addr  <= addr_q;
                out_wdata <= lane_res;
            end
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        frame_off <= off_r;
                        mem_addr  <= '0;
                        mem_rd_en <= 1'b1;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (mem_addr == LAST) begin
                        mem_rd_en <= 1'b0;
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        mem_addr <= mem_addr + AW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRIGHT_FRAME_CNT_EN
    logic [15:0] cnt_r;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt_r <= '0;
        else if (done)
            cnt_r <= cnt_r + 16'd1;
    end

    assign frame_cnt = cnt_r;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_brightness_engine.sv
// Directed self-checking bench for brightness_engine (PW=8, LANES=4, DEPTH=64).
module tb_brightness_engine;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cfg_load;
    logic [8:0]  cfg_value;
    logic        up;
    logic        down;
    logic        start;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [5:0]  mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        out_wr_en;
    logic [5:0]  out_addr;
    logic [31:0] out_wdata;
    logic [8:0]  offset;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem [64];
    int          cyc = 0;
    int          rd_cyc [64];
    logic [5:0]  wa [2048];
    logic [31:0] wd [2048];
    int          wc [2048];
    int          n_wr = 0;
    int          done_cyc = 0;
    int          run_cyc = 0;
    logic        rd_prev = 1'b0;

    brightness_engine #(
        .PW(8), .LANES(4), .AW(6), .DEPTH(64), .STEP(1)
    ) dut (
        .clk(clk), .resetn(resetn), .cfg_load(cfg_load), .cfg_value(cfg_value),
        .up(up), .down(down), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_wr_en(out_wr_en), .out_addr(out_addr), .out_wdata(out_wdata),
        .offset(offset), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (mem_rd_en)
            mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_rd_en)
            rd_cyc[mem_addr] = cyc;
        if (mem_rd_en && !rd_prev)
            run_cyc = cyc;
        rd_prev = mem_rd_en;
        if (out_wr_en && n_wr < 2048) begin
            wa[n_wr] = out_addr;
            wd[n_wr] = out_wdata;
            wc[n_wr] = cyc;
            n_wr++;
        end
        if (done)
            done_cyc = cyc;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic signed [8:0] v);
        cfg_value = v;
        cfg_load  = 1'b1;
        tick();
        cfg_load  = 1'b0;
    endtask

    task automatic press_up();
        up = 1'b1;
        tick();
        up = 1'b0;
        tick();
    endtask

    task automatic press_down();
        down = 1'b1;
        tick();
        down = 1'b0;
        tick();
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 300 && !done; k++)
            tick();
        n_checks++;
        if (done !== 1'b1)
            $display("FAIL %s_timeout: done=%b required 1", name, done);
        else
            n_pass++;
        tick();
    endtask

    task automatic run_frame(input string name, output int base);
        base  = n_wr;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(name);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy, done, mem_rd_en, out_wr_en} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b required 0000",
                     {busy, done, mem_rd_en, out_wr_en});
        else
            n_pass++;
        n_checks++;
        if ({mem_addr, out_addr, out_wdata} !== 44'd0)
            $display("FAIL reset_data: got %h required 0", {mem_addr, out_addr, out_wdata});
        else
            n_pass++;
        n_checks++;
        if ({offset, frame_cnt} !== 25'd0)
            $display("FAIL reset_offset_cnt: got %h required 0", {offset, frame_cnt});
        else
            n_pass++;
    endtask

    task automatic test_positive_offset();
        int b;
        mem[0] = 32'h007F_F0EB;
        load(9'sd20);
        n_checks++;
        if (offset !== 9'd20)
            $display("FAIL pos_offset_load: got %0d required 20", $signed(offset));
        else
            n_pass++;
        run_frame("pos", b);
        n_checks++;
        if (wa[b] !== 6'd0 || wd[b] !== 32'h1493_FFFF)
            $display("FAIL pos_word0: addr %0d data %h required 0 1493ffff", wa[b], wd[b]);
        else
            n_pass++;
        n_checks++;
        if (wc[b] - rd_cyc[0] !== 2)
            $display("FAIL pos_latency: got %0d required 2", wc[b] - rd_cyc[0]);
        else
            n_pass++;
    endtask

    task automatic test_negative_offset();
        int b;
        mem[1] = 32'h5010_5010;
        load(-9'sd30);
        n_checks++;
        if (offset !== 9'h1E2)
            $display("FAIL neg_offset_load: got %h required 1e2", offset);
        else
            n_pass++;
        run_frame("neg", b);
        n_checks++;
        if (wd[b+1] !== 32'h3200_3200)
            $display("FAIL neg_word1: got %h required 32003200", wd[b+1]);
        else
            n_pass++;
    endtask

    task automatic test_offset_control();
        load(9'sd254);
        for (int i = 0; i < 3; i++)
            press_up();
        n_checks++;
        if (offset !== 9'd255)
            $display("FAIL sat_high: got %0d required 255", $signed(offset));
        else
            n_pass++;
        up = 1'b1; down = 1'b1;
        tick();
        up = 1'b0; down = 1'b0;
        tick();
        n_checks++;
        if (offset !== 9'd255)
            $display("FAIL both_edges_sat: got %0d required 255", $signed(offset));
        else
            n_pass++;
        load(9'sd10);
        up = 1'b1; down = 1'b1;
        tick();
        up = 1'b0; down = 1'b0;
        tick();
        n_checks++;
        if (offset !== 9'd10)
            $display("FAIL both_edges: got %0d required 10", $signed(offset));
        else
            n_pass++;
        press_down();
        n_checks++;
        if (offset !== 9'd9)
            $display("FAIL down_step: got %0d required 9", $signed(offset));
        else
            n_pass++;
        // -256 is the only out-of-range value a 9-bit cfg_value can carry
        load(-9'sd256);
        n_checks++;
        if (offset !== 9'h101)
            $display("FAIL clamp_low: got %h required 101", offset);
        else
            n_pass++;
        press_down();
        n_checks++;
        if (offset !== 9'h101)
            $display("FAIL sat_low: got %h required 101", offset);
        else
            n_pass++;
        cfg_value = 9'd7; cfg_load = 1'b1; up = 1'b1;
        tick();
        cfg_load = 1'b0; up = 1'b0;
        tick();
        n_checks++;
        if (offset !== 9'd7)
            $display("FAIL load_priority: got %0d required 7", $signed(offset));
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        int b;
        int errs;
        for (int i = 0; i < 64; i++)
            mem[i] = {8'(i), 8'(255 - i), 8'(i * 3), 8'hA5};
        load(9'sd0);
        b = n_wr;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({busy, mem_rd_en, mem_addr} !== 8'b11_000000)
            $display("FAIL first_run: busy/rd/addr %b required 11000000",
                     {busy, mem_rd_en, mem_addr});
        else
            n_pass++;
        for (int k = 0; k < 10; k++)
            tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("b2b");
        n_checks++;
        if (n_wr - b !== 64)
            $display("FAIL b2b_count: got %0d required 64", n_wr - b);
        else
            n_pass++;
        errs = 0;
        for (int i = 0; i < 64 && b + i < 2048; i++) begin
            if (wa[b+i] !== 6'(i) || wd[b+i] !== mem[i]) errs++;
            if (wc[b+i] !== wc[b] + i) errs++;
            if (wc[b+i] - rd_cyc[i] !== 2) errs++;
        end
        n_checks++;
        if (errs !== 0)
            $display("FAIL b2b_stream: %0d bad writes required 0", errs);
        else
            n_pass++;
        n_checks++;
        if (done_cyc - run_cyc !== 66)
            $display("FAIL b2b_done_time: got %0d required 66", done_cyc - run_cyc);
        else
            n_pass++;
        for (int k = 0; k < 10; k++)
            tick();
        n_checks++;
        if (busy !== 1'b0 || n_wr - b !== 64)
            $display("FAIL start_ignored: busy %b writes %0d required 0 64", busy, n_wr - b);
        else
            n_pass++;
    endtask

    task automatic test_offset_while_busy();
        int b;
        mem[2]  = 32'h0102_0304;
        mem[40] = 32'h10FA_0000;
        load(9'sd5);
        b = n_wr;
        start = 1'b1;
        tick();
        start = 1'b0;
        up = 1'b1;
        tick();
        up = 1'b0;
        n_checks++;
        if (offset !== 9'd6 || busy !== 1'b1)
            $display("FAIL busy_offset: offset %0d busy %b required 6 1", $signed(offset), busy);
        else
            n_pass++;
        wait_done("latched");
        n_checks++;
        if (wd[b+2] !== 32'h0607_0809 || wd[b+40] !== 32'h15FF_0505)
            $display("FAIL latched_data: got %h %h required 06070809 15ff0505",
                     wd[b+2], wd[b+40]);
        else
            n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int b;
        load(9'sd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 100 && mem_addr != 6'd20; k++)
            tick();
        n_checks++;
        if (mem_addr !== 6'd20)
            $display("FAIL mid_reach20: got %0d required 20", mem_addr);
        else
            n_pass++;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, mem_rd_en, out_wr_en, mem_addr, out_addr, out_wdata,
             offset, frame_cnt} !== '0)
            $display("FAIL mid_async_clear: got %h required 0",
                     {busy, done, mem_rd_en, out_wr_en, mem_addr, out_addr,
                      out_wdata, offset, frame_cnt});
        else
            n_pass++;
        b = n_wr;
        tick();
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 10; k++)
            tick();
        n_checks++;
        if (n_wr !== b || busy !== 1'b0 || mem_rd_en !== 1'b0)
            $display("FAIL mid_idle_after: writes %0d busy %b rd %b required %0d 0 0",
                     n_wr, busy, mem_rd_en, b);
        else
            n_pass++;
    endtask

    task automatic test_frame_cnt();
        int b;
        logic [15:0] exp_cnt;
`ifdef BRIGHT_FRAME_CNT_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        for (int f = 0; f < 3; f++)
            run_frame("cnt", b);
        n_checks++;
        if (frame_cnt !== exp_cnt)
            $display("FAIL frame_cnt: got %0d required %0d", frame_cnt, exp_cnt);
        else
            n_pass++;
    endtask

    initial begin
        resetn    = 1'b0;
        cfg_load  = 1'b0;
        cfg_value = '0;
        up        = 1'b0;
        down      = 1'b0;
        start     = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem[i]    = '0;
            rd_cyc[i] = 0;
        end
        tick();
        tick();
        test_reset();
        resetn = 1'b1;
        tick();
        test_positive_offset();
        test_negative_offset();
        test_offset_control();
        test_back_to_back();
        test_offset_while_busy();
        test_reset_mid_frame();
        test_frame_cnt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
